delay_line_mem: RTL and testbench
=================================

// Module: delay_line_mem
// PURPOSE
//  Multi-tap circular delay line for the audio effects chain (echo/chorus/flanger).
//  Each accepted input sample is written into a SIZE-deep dual-port RAM ring buffer.
//  NUM_TAPS delayed samples are then read back, one per cycle, at run-time delays.
//  Sits between the sample-rate front end and the effect mixers.
// PARAMETERS
//  DATA_WIDTH  31     sample width in bits
//  ADDR_WIDTH  15     RAM address width; must satisfy 2**ADDR_WIDTH >= SIZE
//  SIZE        20000  ring-buffer depth in samples; maximum delay is SIZE-1
//  NUM_TAPS    2      number of independent read taps (>=1)
// PORTS
//  CLK        in   1                     system clock, rising edge
//  RST        in   1                     synchronous reset, active-high
//  IN_VALID   in   1                     DI holds a new sample this cycle
//  DI         in   DATA_WIDTH            input sample
//  DELAY      in   NUM_TAPS*ADDR_WIDTH   per-tap delay in samples; tap k = DELAY[k*AW +: AW]
//  BUSY       out  1                     high while a sample is being processed
//  OVERRUN    out  1                     one-cycle pulse: IN_VALID arrived while BUSY
//  OUT_VALID  out  1                     one-cycle pulse: DO is updated
//  DO         out  NUM_TAPS*DATA_WIDTH   tap outputs; tap k = DO[k*DW +: DW]
// BEHAVIOUR
//  Reset:
//   - wr_ptr=0, fill=0, state=IDLE.
//   - BUSY, OVERRUN, OUT_VALID and DO are all 0.
//   - RAM contents are not cleared; the fill counter masks stale data.
//  Storage and read latency:
//   - Dual-port RAM; port A writes, port B reads.
//   - RAM read latency is 1 cycle, plus 1 output register, so 2 cycles from address to data.
//  FSM states: IDLE -> READ -> DRAIN -> OUT -> IDLE.
//  IDLE:
//   - On IN_VALID (cycle 0), write DI at wr_ptr.
//   - Latch DELAY. Any delay >= SIZE is clamped to SIZE-1.
//   - Issue the tap 0 read and go to READ.
//  READ:
//   - Issue the reads for taps 1..NUM_TAPS-1, one per cycle.
//   - Then go to DRAIN. When NUM_TAPS=1, go straight to DRAIN.
//  DRAIN: wait 2 cycles for the last read data to return, then go to OUT.
//  OUT:
//   - Hold OUT_VALID=1 for this cycle only, with all DO lanes updated together.
//   - Return to IDLE.
//   - OUT_VALID therefore rises at cycle NUM_TAPS+2.
//   - BUSY is high from cycle 1 through the OUT cycle.
//  Tap address:
//   - rd_k = wr_ptr - D_k when wr_ptr >= D_k, otherwise wr_ptr + SIZE - D_k.
//   - wr_ptr is the value latched at cycle 0.
//  Write pointer: increments at cycle 0; SIZE-1 wraps to 0.
//  Fill counter: increments at cycle 0 and saturates at SIZE.
//  Tap output rules, in priority order:
//   - D_k = 0: DO_k = DI of this sample (bypass; no RAM read-during-write).
//   - D_k >= fill: DO_k = 0 (not yet written).
//   - Otherwise DO_k = the RAM data.
//  Between OUT pulses, DO holds its last value.
//  IN_VALID while BUSY:
//   - The sample is dropped; no write and no pointer change.
//   - OVERRUN pulses on the next cycle.
//   - An IN_VALID in the OUT cycle is also dropped. It is accepted in the following IDLE cycle.
//  Changes to DELAY while BUSY have no effect until the next accepted sample.
//  RST mid-operation:
//   - Aborts the operation; no OUT_VALID is generated.
//   - All state returns to reset values in the next cycle.
// TESTING
//  1. Reset, NUM_TAPS=2, DELAY={0,3}; feed DI=1,2,3,4,5 with IN_VALID every 8 cycles.
//     -> Tap 0 returns 1..5. Tap 1 returns 0,0,0,1,2.
//     -> OUT_VALID arrives exactly 4 cycles after each IN_VALID.
//  2. SIZE=8, DELAY tap1=7; feed 20 ramp samples (0..19).
//     -> After the buffer fills, tap 1 equals the sample 7 earlier (e.g. sample 15 -> 8).
//     -> wr_ptr wraps 7->0 with no glitch.
//  3. DELAY tap1=9 with SIZE=8.
//     -> Clamped to 7; same output as scenario 2.
//  4. IN_VALID on cycles 0 and 2.
//     -> Second sample dropped; OVERRUN pulses at cycle 3.
//     -> Only one OUT_VALID; the following sample is read at delay 1 as the first sample.
//  5. Assert RST during DRAIN.
//     -> No OUT_VALID; DO=0, BUSY=0.
//     -> Next sample with DELAY=1 gives tap output 0 (fill reset).
//  6. Change DELAY while BUSY.
//     -> Current outputs use the latched delay; the next sample uses the new delay.

Source files
------------

// File: rtl/delay_line_mem_if.sv
// Bundles the sample input, per-tap delays and tap outputs of the delay line.
// Latency: none; wires only.
// Backpressure: none; the producer watches busy/overrun, and samples arriving while busy are dropped.
interface delay_line_mem_if #(
    parameter int DATA_WIDTH = 31,
    parameter int ADDR_WIDTH = 15,
    parameter int NUM_TAPS   = 2
);
    logic                           in_valid;
    logic [DATA_WIDTH-1:0]          di;
    logic [NUM_TAPS*ADDR_WIDTH-1:0] delay;
    logic                           busy;
    logic                           overrun;
    logic                           out_valid;
    logic [NUM_TAPS*DATA_WIDTH-1:0] dout;

    // Sample source / effect mixer side
    modport master (
        output in_valid, di, delay,
        input  busy, overrun, out_valid, dout
    );

    // Delay line side
    modport slave (
        input  in_valid, di, delay,
        output busy, overrun, out_valid, dout
    );
endinterface

// File: rtl/delay_line_mem.sv
// Multi-tap circular delay line: writes each accepted sample into a SIZE-deep ring and reads NUM_TAPS delayed samples.
// Latency: out_valid rises NUM_TAPS+2 cycles after the accepting in_valid cycle; busy from cycle 1 through that cycle.
// Backpressure: none; in_valid while busy is dropped and flagged by a one-cycle overrun pulse on the next cycle.
module delay_line_mem #(
    parameter int DATA_WIDTH = 31,
    parameter int ADDR_WIDTH = 15,
    parameter int SIZE       = 20000,
    parameter int NUM_TAPS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    delay_line_mem_if.slave  bus
);
    // Index width for the RAM itself; addresses never exceed SIZE-1.
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    // Fill counter must be able to hold SIZE itself.
    localparam int FW = $clog2(SIZE + 1);
    localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] MAX_DELAY = ADDR_WIDTH'(SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   SIZE_X    = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [FW-1:0]         FILL_MAX  = FW'(SIZE);

    // Delays beyond the ring depth read the oldest sample still held.
    function automatic logic [ADDR_WIDTH-1:0] clamp_delay(input logic [ADDR_WIDTH-1:0] d);
        if ({1'b0, d} >= SIZE_X) begin
            return MAX_DELAY;
        end
        return d;
    endfunction

    // Ring address of the sample d positions behind ptr, wrapping modulo SIZE.
    function automatic logic [IW-1:0] tap_addr(input logic [ADDR_WIDTH-1:0] ptr,
                                               input logic [ADDR_WIDTH-1:0] d);
        logic [ADDR_WIDTH:0] p;
        logic [ADDR_WIDTH:0] dd;
        logic [ADDR_WIDTH:0] a;
        p  = {1'b0, ptr};
        dd = {1'b0, d};
        if (p >= dd) begin
            a = p - dd;
        end else begin
            a = p + SIZE_X - dd;
        end
        return a[IW-1:0];
    endfunction

    // Control and datapath state
    logic [1:0]                     state;
    logic [ADDR_WIDTH-1:0]          wr_ptr;
    logic [ADDR_WIDTH-1:0]          base_ptr;
    logic [FW-1:0]                  fill;
    logic [FW-1:0]                  fill_lat;
    logic [DATA_WIDTH-1:0]          di_lat;
    logic [ADDR_WIDTH-1:0]          d_lat [NUM_TAPS];
    logic [TW-1:0]                  issue_idx;
    logic                           drain_cnt;

    // Ring storage and the read pipeline
    logic [DATA_WIDTH-1:0]          mem [SIZE];
    logic [DATA_WIDTH-1:0]          rd_q;
    logic                           cap_vld;
    logic [TW-1:0]                  cap_idx;
    logic [DATA_WIDTH-1:0]          stage [NUM_TAPS];

    // Registered outputs
    logic [NUM_TAPS*DATA_WIDTH-1:0] dout_r;
    logic                           out_valid_r;
    logic                           overrun_r;

    // Combinational helpers
    logic                           accept;
    logic                           rd_en;
    logic [IW-1:0]                  rd_addr;
    logic [FW-1:0]                  fill_next;
    logic [ADDR_WIDTH-1:0]          wr_ptr_next;
    logic [ADDR_WIDTH-1:0]          live_d [NUM_TAPS];

    assign accept      = (state == S_IDLE) && bus.in_valid;
    assign rd_en       = accept || (state == S_READ);
    assign fill_next   = (fill == FILL_MAX) ? fill : fill + 1'b1;
    assign wr_ptr_next = (wr_ptr == MAX_DELAY) ? '0 : wr_ptr + 1'b1;

    // Unpack and clamp the live per-tap delays presented on the bus.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            live_d[k] = clamp_delay(bus.delay[k*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // Tap 0 reads straight off the live delay in the accept cycle; later taps use the latched copies.
    always_comb begin
        rd_addr = '0;
        if (accept) begin
            rd_addr = tap_addr(wr_ptr, live_d[0]);
        end else begin
            rd_addr = tap_addr(base_ptr, d_lat[issue_idx]);
        end
    end

    // RAM port A: write the accepted sample into the ring.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[IW-1:0]] <= bus.di;
        end
    end

    // RAM port B: one-cycle registered read.
    always_ff @(posedge clk) begin
        rd_q <= mem[rd_addr];
    end

    // Track which tap the RAM output belongs to, one cycle behind the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld <= 1'b0;
            cap_idx <= '0;
        end else begin
            cap_vld <= rd_en;
            cap_idx <= accept ? '0 : issue_idx;
        end
    end

    // Per-tap output register: bypass for zero delay, zero for unwritten slots, else RAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                stage[k] <= '0;
            end
        end else if (cap_vld) begin
            if (d_lat[cap_idx] == '0) begin
                stage[cap_idx] <= di_lat;
            end else if (32'(d_lat[cap_idx]) >= 32'(fill_lat)) begin
                stage[cap_idx] <= '0;
            end else begin
                stage[cap_idx] <= rd_q;
            end
        end
    end

    // Sequencer: accept, issue tap reads, drain the pipeline, then present all lanes at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            base_ptr    <= '0;
            fill        <= '0;
            fill_lat    <= '0;
            di_lat      <= '0;
            issue_idx   <= '0;
            drain_cnt   <= 1'b0;
            dout_r      <= '0;
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                d_lat[k] <= '0;
            end
        end else begin
            out_valid_r <= 1'b0;
            overrun_r   <= bus.in_valid && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        wr_ptr    <= wr_ptr_next;
                        fill      <= fill_next;
                        // Post-increment fill so a delay equal to the count of older samples still hits.
                        fill_lat  <= fill_next;
                        base_ptr  <= wr_ptr;
                        di_lat    <= bus.di;
                        issue_idx <= TW'(1);
                        drain_cnt <= 1'b0;
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            d_lat[k] <= live_d[k];
                        end
                        state <= (NUM_TAPS > 1) ? S_READ : S_DRAIN;
                    end
                end
                S_READ: begin
                    issue_idx <= issue_idx + 1'b1;
                    if (32'(issue_idx) == NUM_TAPS - 1) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state       <= S_OUT;
                        out_valid_r <= 1'b1;
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            dout_r[k*DATA_WIDTH +: DATA_WIDTH] <= stage[k];
                        end
                    end
                end
                S_OUT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.overrun   = overrun_r;
    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;

endmodule

// File: tb/tb_delay_line_mem.sv
// Bench for the multi-tap delay line, using a small ring so wrap and clamp behaviour shows up quickly.
// Latency: expects out_valid exactly NUM_TAPS+2 cycles after each accepted sample.
// Backpressure: exercises dropped samples, overrun pulses, reset mid-operation and delay changes while busy.
module tb_delay_line_mem;
    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int SIZE = 8;
    localparam int NT   = 2;
    localparam int LAT  = NT + 2;

    logic clk;
    logic rst;

    delay_line_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(NT)) bus ();

    delay_line_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .SIZE      (SIZE),
        .NUM_TAPS  (NT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Every sample accepted since the last reset, oldest first.
    logic [DW-1:0] hist[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected tap value: the sample d accepted samples earlier, zero if there was none.
    function automatic logic [DW-1:0] model_tap(input int d_raw, input logic [DW-1:0] cur);
        int d;
        int n;
        d = (d_raw >= SIZE) ? SIZE - 1 : d_raw;
        n = hist.size();
        if (d == 0) return cur;
        if (d > n) return '0;
        return hist[n - d];
    endfunction

    function automatic logic [NT*AW-1:0] pack(input int d0, input int d1);
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        a0 = AW'(d0);
        a1 = AW'(d1);
        return {a1, a0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hist.delete();
    endtask

    // Offer one sample, wait for its result and compare both lanes against the model.
    task automatic send(input logic [DW-1:0] s, input int d0, input int d1, input bit scramble);
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        int            lat;
        bit            got;
        e0 = model_tap(d0, s);
        e1 = model_tap(d1, s);
        bus.di       = s;
        bus.delay    = pack(d0, d1);
        bus.in_valid = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'b0;
            if (scramble) begin
                bus.delay = (NT*AW)'($urandom);
                bus.di    = DW'($urandom);
            end
            if (lat == 1) check("busy_c1", bus.busy, 1);
            if (bus.out_valid) got = 1'b1;
        end
        check("out_valid_seen", got, 1);
        if (got) begin
            check("latency", lat, LAT);
            check("tap0", bus.dout[DW-1:0], e0);
            check("tap1", bus.dout[2*DW-1:DW], e1);
        end
        @(negedge clk);
        check("out_valid_pulse", bus.out_valid, 0);
        check("busy_idle", bus.busy, 0);
        check("dout_hold", bus.dout, {e1, e0});
        hist.push_back(s);
    endtask

    int cnt;

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.di       = '0;
        bus.delay    = '0;

        // Reset state
        do_reset();
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dout", bus.dout, 0);

        // Bypass tap plus delay 3 over samples 1..5
        for (int i = 1; i <= 5; i++) begin
            send(DW'(i), 0, 3, 1'b0);
            idle(3);
        end

        // Ramp through several wraps at the maximum delay
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(DW'(i), 1, 7, 1'b0);
        end

        // Delay beyond the ring depth clamps to SIZE-1
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(DW'(i), 1, 9, 1'b0);
        end

        // Second in_valid while busy is dropped and flagged
        do_reset();
        bus.di = 16'h00A1; bus.delay = pack(0, 1); bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("ovr_quiet", bus.overrun, 0);
        bus.di = 16'h00B2; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ovr_pulse", bus.overrun, 1);
        @(negedge clk);
        check("ovr_out_valid", bus.out_valid, 1);
        check("ovr_tap0", bus.dout[DW-1:0], 16'h00A1);
        check("ovr_tap1", bus.dout[2*DW-1:DW], 0);
        check("ovr_once", bus.overrun, 0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("ovr_single_out", cnt, 0);
        hist.push_back(16'h00A1);
        send(16'h00C3, 1, 1, 1'b0);

        // Reset during drain aborts the result
        do_reset();
        send(16'h1234, 0, 0, 1'b0);
        bus.di = 16'h5678; bus.delay = pack(0, 0); bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_dout", bus.dout, 0);
        check("abort_busy", bus.busy, 0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("abort_no_out", cnt, 0);
        hist.delete();
        send(16'h0042, 1, 1, 1'b0);

        // Random samples, delays and gaps, with delay/data scrambled while busy
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(DW'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
            idle($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
